// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS32 pipeline: ALU control codes,
// forwarding-select encoding and the registered control bundle.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Forwarding-select decision for one source register, evaluated at ID/EX capture:
// the EX producer (in MEM next cycle) beats the MEM producer (in WB next cycle).
module fwd_sel
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    output fwd_sel_e          sel
);

    // Newest producer wins; register 0 is never forwarded.
    always_comb begin
        sel = FWD_NONE;
        if (ex_valid && ex_reg_write && (ex_rd != REG_AW'(REG_ZERO)) && (ex_rd == src)) begin
            sel = FWD_MEM;
        end else if (mem_reg_write && (mem_rd != REG_AW'(REG_ZERO)) && (mem_rd == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS32 pipeline with registered
// forwarding selects, load-use stall detection and bubble insertion.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_uses_rt,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [3:0]        ex_alu_ctrl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] rs_data_q,  rs_data_d;
    logic [DATA_W-1:0] rt_data_q,  rt_data_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic              alu_src_q,  alu_src_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    ctrl_t             ctrl_q,     ctrl_d;
    fwd_sel_e          rs_sel_q,   rs_sel_d;
    fwd_sel_e          rt_sel_q,   rt_sel_d;

    fwd_sel_e          rs_sel_s, rt_sel_s;
    logic              stall_s;
    logic [DATA_W-1:0] rs_val_s, rt_val_s;

    // A WB write to the same register in the capture cycle has not reached the register file yet.
    function automatic logic [DATA_W-1:0] write_through(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              we,
        input logic [REG_AW-1:0] wrd,
        input logic [DATA_W-1:0] wdata
    );
        if (we && (wrd != REG_AW'(REG_ZERO)) && (wrd == src)) begin
            return wdata;
        end else begin
            return rf_data;
        end
    endfunction

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs (
        .src(id_rs), .ex_rd(rd_q), .ex_reg_write(ctrl_q.reg_write), .ex_valid(valid_q),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .sel(rs_sel_s)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_rt (
        .src(id_rt), .ex_rd(rd_q), .ex_reg_write(ctrl_q.reg_write), .ex_valid(valid_q),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .sel(rt_sel_s)
    );

    // Load-use hazard: the load in EX produces data the ID instruction needs next cycle.
    always_comb begin
        stall_s = 1'b0;
        if (valid_q && ctrl_q.mem_read && ctrl_q.reg_write && (rd_q != REG_AW'(REG_ZERO)) &&
            id_valid && ((id_rs == rd_q) || (id_uses_rt && (id_rt == rd_q)))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next-state: flush dominates stall; both load a bubble instead of the ID instruction.
    always_comb begin
        valid_d    = 1'b0;
        rs_data_d  = {DATA_W{1'b0}};
        rt_data_d  = {DATA_W{1'b0}};
        imm_d      = {DATA_W{1'b0}};
        alu_src_d  = 1'b0;
        alu_ctrl_d = ALU_ADD;
        rd_d       = {REG_AW{1'b0}};
        ctrl_d     = '{1'b0, 1'b0, 1'b0, 1'b0};
        rs_sel_d   = FWD_NONE;
        rt_sel_d   = FWD_NONE;
        if (flush || stall_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d    = id_valid;
            rs_data_d  = write_through(id_rs, id_rs_data, wb_reg_write, wb_rd, wb_data);
            rt_data_d  = write_through(id_rt, id_rt_data, wb_reg_write, wb_rd, wb_data);
            imm_d      = id_imm;
            alu_src_d  = id_alu_src;
            alu_ctrl_d = id_alu_ctrl;
            rd_d       = id_rd;
            ctrl_d     = '{id_valid & id_reg_write, id_valid & id_mem_read,
                           id_valid & id_mem_write, id_valid & id_mem_to_reg};
            rs_sel_d   = rs_sel_s;
            rt_sel_d   = rt_sel_s;
        end
    end

    // ID/EX register with synchronous reset to an add-coded bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs_data_q  <= {DATA_W{1'b0}};
            rt_data_q  <= {DATA_W{1'b0}};
            imm_q      <= {DATA_W{1'b0}};
            alu_src_q  <= 1'b0;
            alu_ctrl_q <= ALU_ADD;
            rd_q       <= {REG_AW{1'b0}};
            ctrl_q     <= '{1'b0, 1'b0, 1'b0, 1'b0};
            rs_sel_q   <= FWD_NONE;
            rt_sel_q   <= FWD_NONE;
        end else begin
            valid_q    <= valid_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            alu_src_q  <= alu_src_d;
            alu_ctrl_q <= alu_ctrl_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            rs_sel_q   <= rs_sel_d;
            rt_sel_q   <= rt_sel_d;
        end
    end

    // Operand muxes pick up the producer's value from whichever stage it now occupies.
    always_comb begin
        case (rs_sel_q)
            FWD_MEM: rs_val_s = mem_result;
            FWD_WB:  rs_val_s = wb_data;
            default: rs_val_s = rs_data_q;
        endcase
        case (rt_sel_q)
            FWD_MEM: rt_val_s = mem_result;
            FWD_WB:  rt_val_s = wb_data;
            default: rt_val_s = rt_data_q;
        endcase
    end

    assign stall         = stall_s;
    assign ex_valid      = valid_q;
    assign ex_a          = rs_val_s;
    assign ex_b          = alu_src_q ? imm_q : rt_val_s;
    assign ex_store_data = rt_val_s;
    assign ex_alu_ctrl   = alu_ctrl_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table for the hazard
// scenarios, then random instruction streams against an age-ordered pipeline model.
module tb_id_ex_stage;

    typedef struct packed {
        logic v; logic [4:0] rs, rt, rd; logic [31:0] rsd, rtd, imm;
        logic urt, asrc; logic [3:0] ctl; logic rw, mr, mw, m2r;
    } id_t;
    typedef struct packed { logic [31:0] d; logic [4:0] rd; logic we; } fw_t;
    typedef struct packed {
        logic stall, chk, v; logic [31:0] a, b, sd; logic [4:0] rd; logic [3:0] ctl;
        logic rw, mr, mw, m2r;
    } ex_t;
    typedef struct { logic flush; id_t id; fw_t mem; fw_t wb; ex_t exp; } row_t;
    typedef struct packed {
        logic v, rw, mr, mw, m2r, bub; logic [4:0] rd; logic [3:0] ctl;
        logic [31:0] res, a, b, sd;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, id_valid, id_uses_rt, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic id_mem_to_reg, flush, mem_reg_write, wb_reg_write;
    logic [4:0] id_rs, id_rt, id_rd, mem_rd, wb_rd, ex_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm, mem_result, wb_data;
    logic [3:0] id_alu_ctrl, ex_alu_ctrl;
    logic stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [31:0] ex_a, ex_b, ex_store_data;

    int n_chk = 0;
    int n_fail = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_uses_rt(id_uses_rt),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush), .mem_result(mem_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .stall(stall),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_ex(input string tag, input ex_t e);
        chk({tag, ".stall"},       32'(stall),         32'(e.stall));
        chk({tag, ".ex_valid"},    32'(ex_valid),      32'(e.v));
        chk({tag, ".ex_rd"},       32'(ex_rd),         32'(e.rd));
        chk({tag, ".ex_alu_ctrl"}, 32'(ex_alu_ctrl),   32'(e.ctl));
        chk({tag, ".ex_reg_write"},32'(ex_reg_write),  32'(e.rw));
        chk({tag, ".ex_mem_read"}, 32'(ex_mem_read),   32'(e.mr));
        chk({tag, ".ex_mem_write"},32'(ex_mem_write),  32'(e.mw));
        chk({tag, ".ex_mem_to_reg"},32'(ex_mem_to_reg),32'(e.m2r));
        if (e.chk) begin
            chk({tag, ".ex_a"},          ex_a,          e.a);
            chk({tag, ".ex_b"},          ex_b,          e.b);
            chk({tag, ".ex_store_data"}, ex_store_data, e.sd);
        end
    endtask

    task automatic drive(input logic fl, input id_t i, input fw_t m, input fw_t w);
        flush = fl;
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_rs_data = i.rsd; id_rt_data = i.rtd; id_imm = i.imm;
        id_uses_rt = i.urt; id_alu_src = i.asrc; id_alu_ctrl = i.ctl;
        id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw; id_mem_to_reg = i.m2r;
        mem_result = m.d; mem_rd = m.rd; mem_reg_write = m.we;
        wb_data = w.d; wb_rd = w.rd; wb_reg_write = w.we;
    endtask

    function automatic id_t f_nop();
        return '0;
    endfunction
    function automatic id_t f_r(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, input logic [3:0] ctl);
        return '{v:1'b1, rs:rs, rt:rt, rd:rd, rsd:rsd, rtd:rtd, imm:32'd0, urt:1'b1, asrc:1'b0,
                 ctl:ctl, rw:1'b1, mr:1'b0, mw:1'b0, m2r:1'b0};
    endfunction
    function automatic id_t f_i(input logic [4:0] rs, rd, input logic [31:0] rsd, imm);
        return '{v:1'b1, rs:rs, rt:rd, rd:rd, rsd:rsd, rtd:32'd0, imm:imm, urt:1'b0, asrc:1'b1,
                 ctl:4'd2, rw:1'b1, mr:1'b0, mw:1'b0, m2r:1'b0};
    endfunction
    function automatic id_t f_lw(input logic [4:0] rs, rd, input logic [31:0] rsd, imm);
        id_t t = f_i(rs, rd, rsd, imm);
        t.mr = 1'b1; t.m2r = 1'b1;
        return t;
    endfunction
    function automatic id_t f_sw(input logic [4:0] rs, rt, input logic [31:0] rsd, rtd, imm);
        return '{v:1'b1, rs:rs, rt:rt, rd:5'd0, rsd:rsd, rtd:rtd, imm:imm, urt:1'b1, asrc:1'b1,
                 ctl:4'd2, rw:1'b0, mr:1'b0, mw:1'b1, m2r:1'b0};
    endfunction
    function automatic fw_t fw(input logic [31:0] d, input logic [4:0] rd, input logic we);
        return '{d:d, rd:rd, we:we};
    endfunction
    function automatic ex_t e_x(input logic st, v, input logic [31:0] a, b, sd, input logic [4:0] rd,
                                input logic [3:0] ctl, input logic rw, mr, mw, m2r);
        return '{stall:st, chk:1'b1, v:v, a:a, b:b, sd:sd, rd:rd, ctl:ctl, rw:rw, mr:mr, mw:mw, m2r:m2r};
    endfunction
    function automatic ex_t e_bub(input logic st);
        ex_t t = e_x(st, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        t.chk = 1'b0;
        return t;
    endfunction
    function automatic row_t mk(input logic fl, input id_t i, input fw_t m, input fw_t w, input ex_t e);
        row_t r;
        r.flush = fl; r.id = i; r.mem = m; r.wb = w; r.exp = e;
        return r;
    endfunction

    // ---- behavioural model for the random phase: three age-ordered slots ----
    ent_t ex_s, mem_s, wb_s;

    function automatic logic produces(input ent_t e, input logic [4:0] src);
        return e.v && e.rw && (e.rd != 5'd0) && (e.rd == src);
    endfunction
    function automatic logic [31:0] newest(input logic [4:0] src, input logic [31:0] rf);
        if (produces(ex_s, src))  return ex_s.res;
        if (produces(mem_s, src)) return mem_s.res;
        if (produces(wb_s, src))  return wb_s.res;
        return rf;
    endfunction
    function automatic ent_t bubble_ent();
        ent_t e = '0;
        e.ctl = 4'd2; e.bub = 1'b1;
        return e;
    endfunction
    function automatic ent_t capture(input id_t i);
        ent_t e;
        logic [31:0] rtv;
        rtv = newest(i.rt, i.rtd);
        e.v = i.v; e.rw = i.v & i.rw; e.mr = i.v & i.mr; e.mw = i.v & i.mw; e.m2r = i.v & i.m2r;
        e.bub = 1'b0; e.rd = i.rd; e.ctl = i.ctl; e.res = $urandom;
        e.a = newest(i.rs, i.rsd); e.b = i.asrc ? i.imm : rtv; e.sd = rtv;
        return e;
    endfunction
    function automatic ex_t ent2ex(input ent_t e, input logic st);
        return '{stall:st, chk:!e.bub, v:e.v, a:e.a, b:e.b, sd:e.sd, rd:e.rd, ctl:e.ctl,
                 rw:e.rw, mr:e.mr, mw:e.mw, m2r:e.m2r};
    endfunction
    function automatic id_t rand_id();
        id_t t;
        logic [3:0] ctls [5];
        ctls[0] = 4'd0; ctls[1] = 4'd1; ctls[2] = 4'd2; ctls[3] = 4'd6; ctls[4] = 4'd7;
        case ($urandom_range(0, 3))
            0: t = f_r(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       $urandom, $urandom, ctls[$urandom_range(0, 4)]);
            1: t = f_lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom);
            2: t = f_sw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            default: t = f_i(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom);
        endcase
        t.v = ($urandom_range(0, 7) != 0);
        return t;
    endfunction

    row_t tbl [20];

    initial begin
        id_t cur;
        ent_t nxt;
        logic fl, exp_stall, hold;

        tbl[0]  = mk(1'b0, f_nop(), fw(0,0,0), fw(0,0,0), e_x(0,0,0,0,0,0,4'd2,0,0,0,0));
        tbl[1]  = mk(1'b0, f_r(1,2,3,10,5,4'd2), fw(0,0,0), fw(0,0,0), e_x(0,0,0,0,0,0,4'd0,0,0,0,0));
        tbl[2]  = mk(1'b0, f_r(3,1,4,0,10,4'd6), fw(0,0,0), fw(0,0,0), e_x(0,1,10,5,5,3,4'd2,1,0,0,0));
        tbl[3]  = mk(1'b0, f_nop(), fw(15,3,1), fw(0,0,0), e_x(0,1,15,10,10,4,4'd6,1,0,0,0));
        tbl[4]  = mk(1'b0, f_lw(1,5,100,4), fw(5,4,1), fw(15,3,1), e_x(0,0,0,0,0,0,4'd0,0,0,0,0));
        tbl[5]  = mk(1'b0, f_r(5,5,6,0,0,4'd2), fw(0,0,0), fw(5,4,1), e_x(1,1,100,4,0,5,4'd2,1,1,0,1));
        tbl[6]  = mk(1'b0, f_r(5,5,6,0,0,4'd2), fw(104,5,1), fw(0,0,0), e_bub(0));
        tbl[7]  = mk(1'b0, f_nop(), fw(0,0,0), fw(32'hDEADBEEF,5,1),
                     e_x(0,1,32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF,6,4'd2,1,0,0,0));
        tbl[8]  = mk(1'b0, f_i(0,2,0,1), fw(1,6,1), fw(0,0,0), e_x(0,0,0,0,0,0,4'd0,0,0,0,0));
        tbl[9]  = mk(1'b0, f_i(0,2,0,2), fw(0,0,0), fw(1,6,1), e_x(0,1,0,1,0,2,4'd2,1,0,0,0));
        tbl[10] = mk(1'b0, f_r(2,0,7,1234,0,4'd2), fw(9,2,1), fw(0,0,0), e_x(0,1,0,2,9,2,4'd2,1,0,0,0));
        tbl[11] = mk(1'b0, f_nop(), fw(7,2,1), fw(9,2,1), e_x(0,1,7,0,0,7,4'd2,1,0,0,0));
        tbl[12] = mk(1'b0, f_i(0,0,0,5), fw(7,7,1), fw(7,2,1), e_x(0,0,0,0,0,0,4'd0,0,0,0,0));
        tbl[13] = mk(1'b0, f_i(0,0,0,5), fw(0,0,0), fw(7,7,1), e_x(0,1,0,5,0,0,4'd2,1,0,0,0));
        tbl[14] = mk(1'b0, f_r(0,0,8,0,0,4'd2), fw(32'h55,0,1), fw(32'h55,0,1), e_x(0,1,0,5,0,0,4'd2,1,0,0,0));
        tbl[15] = mk(1'b0, f_nop(), fw(32'h55,0,1), fw(32'h55,0,1), e_x(0,1,0,0,0,8,4'd2,1,0,0,0));
        tbl[16] = mk(1'b0, f_lw(0,9,0,0), fw(0,8,1), fw(32'h55,0,1), e_x(0,0,0,0,0,0,4'd0,0,0,0,0));
        tbl[17] = mk(1'b1, f_r(9,9,10,0,0,4'd2), fw(0,0,0), fw(0,8,1), e_x(1,1,0,0,0,9,4'd2,1,1,0,1));
        tbl[18] = mk(1'b0, f_sw(0,9,0,0,32'h20), fw(0,9,1), fw(0,0,0), e_bub(0));
        tbl[19] = mk(1'b0, f_nop(), fw(0,0,0), fw(32'hCAFE0000,9,1),
                     e_x(0,1,0,32'h20,32'hCAFE0000,0,4'd2,0,0,1,0));

        reset = 1'b1;
        drive(1'b0, f_nop(), fw(0,0,0), fw(0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 20; r++) begin
            drive(tbl[r].flush, tbl[r].id, tbl[r].mem, tbl[r].wb);
            #1;
            check_ex($sformatf("row%0d", r), tbl[r].exp);
            @(posedge clk);
            @(negedge clk);
        end

        // Reset arriving mid-stream while ID holds a valid instruction.
        drive(1'b0, f_r(1,2,3,32'h11,32'h22,4'd6), fw(32'h77,1,1), fw(32'h88,2,1));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_ex("midrst", e_x(0,0,0,0,0,0,4'd2,0,0,0,0));

        ex_s = '0; ex_s.ctl = 4'd2;
        mem_s = '0;
        wb_s = '0;
        hold = 1'b0;
        cur = f_nop();
        for (int k = 0; k < 3000; k++) begin
            if (!hold) cur = rand_id();
            fl = ($urandom_range(0, 9) == 0);
            drive(fl, cur, fw(mem_s.res, mem_s.rd, mem_s.v & mem_s.rw), fw(wb_s.res, wb_s.rd, wb_s.v & wb_s.rw));
            exp_stall = ex_s.v && ex_s.mr && ex_s.rw && (ex_s.rd != 5'd0) && cur.v &&
                        ((cur.rs == ex_s.rd) || (cur.urt && (cur.rt == ex_s.rd)));
            #1;
            check_ex("rnd", ent2ex(ex_s, exp_stall));
            @(posedge clk);
            nxt = (fl || exp_stall) ? bubble_ent() : capture(cur);
            wb_s = mem_s;
            mem_s = ex_s;
            ex_s = nxt;
            hold = exp_stall && !fl;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
